// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - button front end, reversal filter and step pacer producing accion/mover
// Build macro SNAKE_REVERSE_BLOCK_EN: when defined, presses opposite to the committed direction are dropped.
module snake_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned STEP_PERIOD     = 2500000,
  parameter int unsigned STEP_MIN        = 500000,
  parameter int unsigned STEP_DEC        = 100000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       uclk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       speedup,
  input  logic       game_reset,
  output logic [2:0] accion,
  output logic       mover,
  output logic       running
);

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(STEP_PERIOD);
  localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(STEP_MIN);
  localparam logic [CNT_W:0]   PERIOD_DEC  = (CNT_W+1)'(STEP_DEC);
  localparam logic [CNT_W-1:0] RELOAD_INIT = PERIOD_INIT - 1'b1;

  // Button vectors are ordered by priority: bit 0 up, 1 down, 2 left, 3 right.
  logic [3:0]       btn_raw;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [CNT_W-1:0] deb_cnt_q [4];
  logic [CNT_W-1:0] deb_cnt_d [4];
  logic [3:0]       deb_q, deb_d;
  logic [3:0]       deb_prev_q, deb_prev_d;
  logic [3:0]       press_q, press_d;

  logic [3:0]       accept;
  logic             has_press;
  dir_t             pick;
  logic [CNT_W:0]   dec_diff;
  logic [CNT_W-1:0] period_dec;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  dir_t             accion_q, accion_d;
  dir_t             next_dir_q, next_dir_d;
  logic             mover_q, mover_d;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    press_d    = deb_q & ~deb_prev_q;
  end

  // Any cycle where the synchronised input agrees with the debounced level restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
`ifdef SNAKE_REVERSE_BLOCK_EN
    accept[0] = press_q[0] && (accion_q != DIR_DOWN);
    accept[1] = press_q[1] && (accion_q != DIR_UP);
    accept[2] = press_q[2] && (accion_q != DIR_RIGHT);
    accept[3] = press_q[3] && (accion_q != DIR_LEFT);
`else
    accept = press_q;
`endif
    has_press = |accept;
    pick      = DIR_NONE;
    if (accept[0]) begin
      pick = DIR_UP;
    end else if (accept[1]) begin
      pick = DIR_DOWN;
    end else if (accept[2]) begin
      pick = DIR_LEFT;
    end else if (accept[3]) begin
      pick = DIR_RIGHT;
    end
  end

  // One extra bit so a period below STEP_DEC shows up as a borrow instead of wrapping.
  always_comb begin
    dec_diff = {1'b0, period_q} - PERIOD_DEC;
    if (dec_diff[CNT_W] || (dec_diff < {1'b0, PERIOD_MIN})) begin
      period_dec = PERIOD_MIN;
    end else begin
      period_dec = dec_diff[CNT_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    period_d   = period_q;
    accion_d   = accion_q;
    next_dir_d = next_dir_q;
    mover_d    = 1'b0;

    if (speedup) begin
      period_d = period_dec;
    end
    if (has_press) begin
      next_dir_d = pick;
    end

    case (state_q)
      S_IDLE: begin
        step_cnt_d = period_q - 1'b1;
        if (has_press) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (step_cnt_q == '0) begin
          step_cnt_d = period_q - 1'b1;
          mover_d    = 1'b1;
          accion_d   = next_dir_q;
        end else begin
          step_cnt_d = step_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Restart from the game wins over presses, strobes and speedups alike.
    if (game_reset) begin
      state_d    = S_IDLE;
      step_cnt_d = RELOAD_INIT;
      period_d   = PERIOD_INIT;
      accion_d   = DIR_NONE;
      next_dir_d = DIR_NONE;
      mover_d    = 1'b0;
    end
  end

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_cnt_q <= RELOAD_INIT;
      period_q   <= PERIOD_INIT;
      accion_q   <= DIR_NONE;
      next_dir_q <= DIR_NONE;
      mover_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      period_q   <= period_d;
      accion_q   <= accion_d;
      next_dir_q <= next_dir_d;
      mover_q    <= mover_d;
    end
  end

  assign accion  = accion_q;
  assign mover   = mover_q;
  assign running = (state_q == S_RUN);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - randomized self-checking bench for snake_dir_ctrl against a schedule-based model
module tb_snake_dir_ctrl;

  localparam int D    = 4;
  localparam int P    = 10;
  localparam int MIN  = 4;
  localparam int DEC  = 3;
  localparam int W    = 8;
  localparam int HMAX = 4096;

  logic       uclk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       speedup = 1'b0, game_reset = 1'b0;
  logic [2:0] accion;
  logic       mover, running;

  int checks = 0;
  int failures = 0;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(D), .STEP_PERIOD(P), .STEP_MIN(MIN), .STEP_DEC(DEC), .CNT_W(W)
  ) dut (
    .uclk(uclk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .speedup(speedup), .game_reset(game_reset),
    .accion(accion), .mover(mover), .running(running)
  );

  always #5 uclk = ~uclk;

  // Reference model: raw-sample history, window-scan debounce, absolute-time strobe schedule.
  int       cyc = 8;
  bit [3:0] rh   [HMAX];
  bit [3:0] pend [HMAX];
  bit [3:0] m_deb = '0;
  int       m_accion = 0, m_nd = 0, m_period = P, m_next = 0;
  bit       m_mover = 1'b0, m_running = 1'b0;

`ifdef SNAKE_REVERSE_BLOCK_EN
  function automatic int opposite(input int d);
    case (d)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return 0;
    endcase
  endfunction
`endif

  task automatic model_step();
    bit [3:0] acc;
    int       pick;
    bit       flip;
    cyc++;
    if (rst) begin
      rh[cyc] = '0;
      m_deb   = '0;
      for (int k = 0; k < 4; k++) pend[cyc+k] = '0;
      m_accion = 0; m_nd = 0; m_period = P; m_next = 0;
      m_mover = 1'b0; m_running = 1'b0;
    end else begin
      rh[cyc] = {btn_right, btn_left, btn_down, btn_up};
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        for (int i = 0; i < D; i++) if (rh[cyc-2-i][b] == m_deb[b]) flip = 1'b0;
        if (flip) begin
          m_deb[b] = ~m_deb[b];
          if (m_deb[b]) pend[cyc+2][b] = 1'b1;
        end
      end
      acc = '0;
      for (int d = 1; d <= 4; d++) begin
        if (pend[cyc][d-1]) begin
`ifdef SNAKE_REVERSE_BLOCK_EN
          if (m_accion != opposite(d)) acc[d-1] = 1'b1;
`else
          acc[d-1] = 1'b1;
`endif
        end
      end
      pick = 0;
      for (int d = 4; d >= 1; d--) if (acc[d-1]) pick = d;
      m_mover = 1'b0;
      if (game_reset) begin
        m_accion = 0; m_nd = 0; m_period = P; m_running = 1'b0;
      end else begin
        if (m_running && cyc == m_next) begin
          m_mover  = 1'b1;
          m_accion = m_nd;
          m_next   = cyc + m_period;
        end
        if (pick != 0) begin
          m_nd = pick;
          if (!m_running) begin
            m_running = 1'b1;
            m_next    = cyc + m_period;
          end
        end
        if (speedup) m_period = (m_period - DEC < MIN) ? MIN : m_period - DEC;
      end
    end
  endtask

  initial forever begin
    @(posedge uclk);
    model_step();
  end

  task automatic test_reset();
    rst = 1'b1;
    @(negedge uclk);
    checks++;
    if ({accion, mover, running} !== 5'b0) begin
      failures++;
      $display("FAIL reset_hold accion=%0d mover=%0b running=%0b required 0 0 0", accion, mover, running);
    end
    repeat (4) @(negedge uclk);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge uclk);
      checks++;
      if (accion !== 3'd0 || mover !== 1'b0 || running !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle c=%0d accion=%0d mover=%0b running=%0b required 0 0 0", c, accion, mover, running);
      end
    end
  endtask

  task automatic test_right();
    int run_c, hold, acc_first;
    int st[$];
    run_c = -1; acc_first = -1;
    hold = $urandom_range(8, 15);
    for (int c = 0; c < 50; c++) begin
      btn_right = (c < hold);
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== {3'(m_accion), m_mover, m_running}) begin
        failures++;
        $display("FAIL right_model c=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, accion, mover, running, m_accion, m_mover, m_running);
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (dut.next_dir_q !== ((c == 7) ? 3'd4 : 3'd0)) begin
          failures++;
          $display("FAIL right_next_dir c=%0d got %0d required %0d", c, dut.next_dir_q, (c == 7) ? 4 : 0);
        end
      end
      if (running && run_c < 0) run_c = c;
      if (mover) begin
        if (st.size() == 0) acc_first = accion;
        st.push_back(c);
      end
    end
    btn_right = 1'b0;
    checks++;
    if (run_c != 7) begin
      failures++;
      $display("FAIL right_run_latency got %0d required 7", run_c);
    end
    checks++;
    if (acc_first != 4) begin
      failures++;
      $display("FAIL right_first_accion got %0d required 4", acc_first);
    end
    checks++;
    if (st.size() != 4) begin
      failures++;
      $display("FAIL right_strobe_count got %0d required 4", st.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (st[k] != 17 + 10 * k) begin
          failures++;
          $display("FAIL right_strobe_time k=%0d got %0d required %0d", k, st[k], 17 + 10 * k);
        end
      end
    end
  endtask

  task automatic test_bounce();
    bit pat[$];
    int nb, s;
    nb = $urandom_range(3, 5);
    for (int k = 0; k < nb; k++) begin
      pat.push_back(1'b1); pat.push_back(1'b1); pat.push_back(1'b0);
    end
    s = pat.size();
    repeat ($urandom_range(6, 10)) pat.push_back(1'b1);
    for (int c = 0; c < pat.size() + 35; c++) begin
      btn_up = (c < pat.size()) ? pat[c] : 1'b0;
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== {3'(m_accion), m_mover, m_running}) begin
        failures++;
        $display("FAIL bounce_model c=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, accion, mover, running, m_accion, m_mover, m_running);
      end
      if (c == s + 6 || c == s + 7) begin
        checks++;
        if (dut.next_dir_q !== ((c == s + 7) ? 3'd1 : 3'd4)) begin
          failures++;
          $display("FAIL bounce_next_dir c=%0d got %0d required %0d", c, dut.next_dir_q, (c == s + 7) ? 1 : 4);
        end
      end
    end
    checks++;
    if (accion !== 3'd1) begin
      failures++;
      $display("FAIL bounce_up_commit got %0d required 1", accion);
    end
    for (int c = 0; c < 40; c++) begin
      btn_down = (c < 6);
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== {3'(m_accion), m_mover, m_running}) begin
        failures++;
        $display("FAIL reverse_model c=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, accion, mover, running, m_accion, m_mover, m_running);
      end
    end
    checks++;
`ifdef SNAKE_REVERSE_BLOCK_EN
    if (accion !== 3'd1) begin
      failures++;
      $display("FAIL reverse_down got %0d required 1", accion);
    end
`else
    if (accion !== 3'd2) begin
      failures++;
      $display("FAIL reverse_down got %0d required 2", accion);
    end
`endif
  endtask

  task automatic test_simultaneous();
    for (int c = 0; c < 40; c++) begin
      btn_right = (c < 6);
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== {3'(m_accion), m_mover, m_running}) begin
        failures++;
        $display("FAIL simul_pre_model c=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, accion, mover, running, m_accion, m_mover, m_running);
      end
    end
    checks++;
    if (accion !== 3'd4) begin
      failures++;
      $display("FAIL simul_setup_right got %0d required 4", accion);
    end
    for (int c = 0; c < 40; c++) begin
      btn_left = (c < 6);
      btn_up   = (c < 6);
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== {3'(m_accion), m_mover, m_running}) begin
        failures++;
        $display("FAIL simul_model c=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, accion, mover, running, m_accion, m_mover, m_running);
      end
    end
    checks++;
    if (accion !== 3'd1) begin
      failures++;
      $display("FAIL simul_left_up got %0d required 1", accion);
    end
  endtask

  task automatic test_speedup();
    int st[$];
    int sp_at;
    int exp_gap[4] = '{10, 7, 4, 4};
    sp_at = -1;
    for (int c = 0; c < 80; c++) begin
      speedup = (c == sp_at);
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== {3'(m_accion), m_mover, m_running}) begin
        failures++;
        $display("FAIL speedup_model c=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, accion, mover, running, m_accion, m_mover, m_running);
      end
      if (mover) begin
        st.push_back(c);
        if (st.size() <= 3) sp_at = c + $urandom_range(1, 2);
      end
    end
    speedup = 1'b0;
    checks++;
    if (st.size() < 5) begin
      failures++;
      $display("FAIL speedup_strobe_count got %0d required at least 5", st.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (st[k+1] - st[k] != exp_gap[k]) begin
          failures++;
          $display("FAIL speedup_gap k=%0d got %0d required %0d", k, st[k+1] - st[k], exp_gap[k]);
        end
      end
    end
  endtask

  task automatic test_game_reset();
    int gh, d, run_c, acc_first;
    int st[$];
    gh = $urandom_range(1, 3);
    for (int c = 0; c < gh; c++) begin
      game_reset = 1'b1;
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== 5'b0) begin
        failures++;
        $display("FAIL game_reset_clear c=%0d got %0d/%0b/%0b required 0/0/0", c, accion, mover, running);
      end
    end
    game_reset = 1'b0;
    d = $urandom_range(1, 4);
    run_c = -1; acc_first = -1;
    for (int c = 0; c < 50; c++) begin
      btn_up    = (c < 6) && (d == 1);
      btn_down  = (c < 6) && (d == 2);
      btn_left  = (c < 6) && (d == 3);
      btn_right = (c < 6) && (d == 4);
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== {3'(m_accion), m_mover, m_running}) begin
        failures++;
        $display("FAIL restart_model c=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, accion, mover, running, m_accion, m_mover, m_running);
      end
      if (running && run_c < 0) run_c = c;
      if (mover) begin
        if (st.size() == 0) acc_first = accion;
        st.push_back(c);
      end
    end
    checks++;
    if (run_c != 7 || acc_first != d) begin
      failures++;
      $display("FAIL restart_entry run_at=%0d accion=%0d required 7 and %0d", run_c, acc_first, d);
    end
    checks++;
    if (st.size() < 2 || st[0] != 17 || st[1] != 27) begin
      failures++;
      $display("FAIL restart_spacing got %0d strobes first=%0d required 17 then 27", st.size(), (st.size() > 0) ? st[0] : -1);
    end
  endtask

  task automatic test_async_rst();
    int c0, run_c, acc_first;
    int st[$];
    c0 = 0; run_c = -1; acc_first = -1;
    while (!mover && c0 < 20) begin
      @(negedge uclk);
      c0++;
    end
    checks++;
    if (mover !== 1'b1) begin
      failures++;
      $display("FAIL async_wait_strobe timeout mover=%0b required 1", mover);
    end
    repeat (3) @(negedge uclk);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL async_pre_running got %0b required 1", running);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({accion, mover, running} !== 5'b0) begin
      failures++;
      $display("FAIL async_rst_clear got %0d/%0b/%0b required 0/0/0", accion, mover, running);
    end
    repeat (3) @(negedge uclk);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      btn_up = (c < 6);
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== {3'(m_accion), m_mover, m_running}) begin
        failures++;
        $display("FAIL async_restart_model c=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, accion, mover, running, m_accion, m_mover, m_running);
      end
      if (running && run_c < 0) run_c = c;
      if (mover) begin
        if (st.size() == 0) acc_first = accion;
        st.push_back(c);
      end
    end
    checks++;
    if (run_c != 7 || acc_first != 1 || st.size() == 0 || st[0] != 17) begin
      failures++;
      $display("FAIL async_restart run_at=%0d accion=%0d strobes=%0d required 7, 1, first at 17", run_c, acc_first, st.size());
    end
  endtask

  task automatic test_random();
    int left[4];
    bit lvl[4];
    for (int b = 0; b < 4; b++) begin
      left[b] = 0;
      lvl[b]  = 1'b0;
    end
    for (int c = 0; c < 700; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (left[b] == 0) begin
          lvl[b]  = ($urandom_range(0, 9) < 3);
          left[b] = $urandom_range(1, 9);
        end
        left[b]--;
      end
      {btn_right, btn_left, btn_down, btn_up} = {lvl[3], lvl[2], lvl[1], lvl[0]};
      speedup    = ($urandom_range(0, 39) == 0);
      game_reset = ($urandom_range(0, 149) == 0);
      @(negedge uclk);
      checks++;
      if ({accion, mover, running} !== {3'(m_accion), m_mover, m_running}) begin
        failures++;
        $display("FAIL random_model c=%0d got %0d/%0b/%0b exp %0d/%0b/%0b", c, accion, mover, running, m_accion, m_mover, m_running);
      end
    end
    {btn_right, btn_left, btn_down, btn_up} = 4'b0;
    speedup    = 1'b0;
    game_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_right();
    test_bounce();
    test_simultaneous();
    test_speedup();
    test_game_reset();
    test_async_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_dir_ctrl.md
# snake_dir_ctrl

- Produces the direction command `accion` and step strobe `mover` that drive the snake game logic.
- Takes raw board push buttons, synchronises and debounces them, and filters out illegal 180° reversals.
- Paces snake steps with a programmable step timer that speeds up on each fruit eaten.
- Sits between the board button pins and the game logic block, clocked by `uclk`.

## Interface

- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required before a debounced level changes.
- `STEP_PERIOD`, 2500000: initial `uclk` cycles between `mover` strobes.
- `STEP_MIN`, 500000: floor for the step period.
- `STEP_DEC`, 100000: period reduction per `speedup` pulse.
- `CNT_W`, 24: width of the step and debounce counters.
- `uclk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: raw, asynchronous, active-high buttons.
- `speedup` in 1: one-cycle pulse; fruit eaten.
- `game_reset` in 1: synchronous, level-sensitive restart request from the game logic (collision or wall).
- `accion` out 3: committed direction. 0 = stopped, 1 = up, 2 = down, 3 = left, 4 = right.
- `mover` out 1: one-cycle step strobe, registered.
- `running` out 1: high in state RUN.

## Operation

- Each button has a 2-flop synchroniser followed by a debouncer.
  - The debounced level flips only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce restarts the count.
- A press event is a 0→1 edge of a debounced level.
- Press filter:
  - Reversal is checked against the committed `accion`, not the pending direction. Up↔down and left↔right are reversals.
  - Same-direction presses are accepted and cause no change.
  - With several press events in one cycle, the highest-priority accepted press wins: up > down > left > right.
  - The accepted press loads `next_dir`.
- States:
  - IDLE (after reset or `game_reset`): `accion` = 0, `mover` = 0, step counter held at period−1.
    - Any accepted press → RUN.
  - RUN: step counter decrements each cycle.
    - At 0: counter reloads period−1, `mover` = 1 next cycle, and `accion` loads `next_dir` on that same edge.
- `accion` changes only on the cycle `mover` rises, so it is stable for the whole strobe.
- `mover` is low for at least one cycle between strobes, which satisfies the consumer's low-then-high arming rule.
- Speed control:
  - On `speedup`, period ← max(period − `STEP_DEC`, `STEP_MIN`), computed in `CNT_W`+1 bits to avoid underflow.
  - The new period takes effect at the next reload.
- `game_reset` has priority over every other event in the same cycle:
  - `accion`, `next_dir` ← 0.
  - period ← `STEP_PERIOD`.
  - state ← IDLE.
  - `mover` ← 0.
  - Debouncer states are kept.

## Timing

- Reset values: `accion` = 0, `mover` = 0, `running` = 0, period = `STEP_PERIOD`, `next_dir` = 0, all debounced levels 0.
- Press latency: `next_dir` updates exactly `DEBOUNCE_CYCLES`+3 cycles after the first rising edge at which a clean raw high is sampled.
- First strobe after entering RUN: `STEP_PERIOD` cycles after the transition.
- Subsequent strobes: exactly `period` cycles apart.
- A press in the same cycle as a reload is captured in `next_dir` and committed at the following strobe.
- `rst` asserted mid-step clears everything immediately, without waiting for a clock.

## Configuration

- `SNAKE_REVERSE_BLOCK_EN`
  - Defined: reversal presses are rejected as described above.
  - Undefined: every press is accepted, and the priority encoder alone selects among simultaneous presses.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4, `STEP_PERIOD`=10, `STEP_MIN`=4, `STEP_DEC`=3.

- Reset, no buttons for 50 cycles -> `accion`=0, `mover` never high, `running`=0.
- Clean `btn_right` press -> `next_dir`=4 after 7 cycles, `running`=1; first `mover` 10 cycles after RUN entry with `accion`=4; strobes every 10 cycles.
- Bouncing `btn_up` (high 2 cycles, low 1, repeated) then steady high -> no press until 4 stable cycles; later `btn_down` while `accion`=1 -> ignored with macro, `accion`=2 without it.
- `btn_left` and `btn_up` press events in the same cycle while `accion`=4 -> `accion`=1 at next strobe.
- Three `speedup` pulses -> strobe spacing 7, then 4, then 4 (floor); `game_reset` -> `accion`=0, IDLE, spacing back to 10 after next press.
- `rst` asserted between strobes -> all outputs 0 asynchronously; a `btn_up` press after release restarts normally.
